priv_pmp_access_gate: RTL

- Data-side memory request stage that sits between the pipeline's load/store port and the data bus.
- Registers each request, presents it to the PMP checker for one full cycle, then does one of two things:
  - forwards it to the bus when PMP allows it;
  - raises a precise access fault (load or store) with the faulting address for the exception logic.
- Also enforces a bus-response timeout and reports it as an access fault.

---
 rtl/priv_pmp_access_gate.sv | 241 ++++++++++++++++++++++++
 1 files changed

// File: rtl/priv_pmp_access_gate.sv
// Data-side request stage: registers a load/store, checks it against PMP for one
// cycle, then either drives the bus or raises a precise access fault.
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | no request held; accepts req_ren|req_wen
// CHECK  | captured request presented to the PMP checker for one cycle
// ACCESS | bus transaction in flight, timeout counter running
// FAULT  | access fault presented to the exception logic until ack/flush
module priv_pmp_access_gate #(
    parameter int TIMEOUT = 256
) (
    input  logic        CLK,
    input  logic        nRST,

    input  logic [31:0] req_addr,
    input  logic        req_ren,
    input  logic        req_wen,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_byte_en,
    output logic        req_busy,
    output logic [31:0] req_rdata,
    input  logic        flush,

    output logic [31:0] pmp_daddr,
    output logic        pmp_ren,
    output logic        pmp_wen,
    input  logic        pmp_l_fault,
    input  logic        pmp_s_fault,

    output logic [31:0] bus_addr,
    output logic        bus_ren,
    output logic        bus_wen,
    output logic [31:0] bus_wdata,
    output logic [3:0]  bus_byte_en,
    input  logic        bus_busy,
    input  logic [31:0] bus_rdata,

    output logic        fault_valid,
    output logic        fault_store,
    output logic        fault_timeout,
    output logic [31:0] fault_addr,
    input  logic        fault_ack
);

    localparam int CW = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);
    localparam logic [CW-1:0] CNT_MAX  = {CW{1'b1}};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        CHECK  = 2'd1,
        ACCESS = 2'd2,
        FAULT  = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   addr_q, addr_d;
    logic [31:0]   wdata_q, wdata_d;
    logic [3:0]    be_q, be_d;
    logic          ren_q, ren_d;
    logic          wen_q, wen_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          drop_q, drop_d;
    logic          flt_store_q, flt_store_d;
    logic          flt_tmo_q, flt_tmo_d;
    logic [31:0]   flt_addr_q, flt_addr_d;

    logic req_any;
    logic pmp_hit;
    logic dropping;
    logic timed_out;

    assign req_any   = req_ren | req_wen;
    assign pmp_hit   = pmp_l_fault | pmp_s_fault;
    assign dropping  = drop_q | flush;
    assign timed_out = (TIMEOUT != 0) && bus_busy && (cnt_q == CNT_LAST);

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q     <= IDLE;
            addr_q      <= '0;
            wdata_q     <= '0;
            be_q        <= '0;
            ren_q       <= 1'b0;
            wen_q       <= 1'b0;
            cnt_q       <= '0;
            drop_q      <= 1'b0;
            flt_store_q <= 1'b0;
            flt_tmo_q   <= 1'b0;
            flt_addr_q  <= '0;
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            ren_q       <= ren_d;
            wen_q       <= wen_d;
            cnt_q       <= cnt_d;
            drop_q      <= drop_d;
            flt_store_q <= flt_store_d;
            flt_tmo_q   <= flt_tmo_d;
            flt_addr_q  <= flt_addr_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        ren_d       = ren_q;
        wen_d       = wen_q;
        cnt_d       = cnt_q;
        drop_d      = drop_q;
        flt_store_d = flt_store_q;
        flt_tmo_d   = flt_tmo_q;
        flt_addr_d  = flt_addr_q;

        case (state_q)
            IDLE: begin
                if (!flush && req_any) begin
                    state_d = CHECK;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_byte_en;
                    // a simultaneous load+store is handled as a store
                    ren_d   = req_ren & ~req_wen;
                    wen_d   = req_wen;
                end
            end

            CHECK: begin
                drop_d = 1'b0;
                if (flush) begin
                    state_d = IDLE;
                end else if (pmp_hit) begin
                    state_d     = FAULT;
                    flt_store_d = wen_q;
                    flt_addr_d  = addr_q;
                    flt_tmo_d   = 1'b0;
                end else begin
                    state_d = ACCESS;
                    cnt_d   = '0;
                end
            end

            ACCESS: begin
                if (flush) begin
                    drop_d = 1'b1;
                end
                if (bus_busy && (cnt_q != CNT_MAX)) begin
                    cnt_d = cnt_q + CW'(1);
                end
                if (!bus_busy) begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end else if (timed_out) begin
                    drop_d = 1'b0;
                    // a flushed request has no one left to take the fault
                    if (dropping) begin
                        state_d = IDLE;
                    end else begin
                        state_d     = FAULT;
                        flt_store_d = wen_q;
                        flt_addr_d  = addr_q;
                        flt_tmo_d   = 1'b1;
                    end
                end
            end

            FAULT: begin
                if (flush || fault_ack) begin
                    state_d     = IDLE;
                    flt_store_d = 1'b0;
                    flt_tmo_d   = 1'b0;
                    flt_addr_d  = '0;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_comb begin
        req_busy      = 1'b0;
        req_rdata     = '0;
        pmp_daddr     = '0;
        pmp_ren       = 1'b0;
        pmp_wen       = 1'b0;
        bus_addr      = '0;
        bus_ren       = 1'b0;
        bus_wen       = 1'b0;
        bus_wdata     = '0;
        bus_byte_en   = '0;
        fault_valid   = 1'b0;
        fault_store   = 1'b0;
        fault_timeout = 1'b0;
        fault_addr    = '0;

        case (state_q)
            IDLE: begin
                req_busy = req_any;
            end

            CHECK: begin
                req_busy  = 1'b1;
                pmp_daddr = addr_q;
                pmp_ren   = ren_q;
                pmp_wen   = wen_q;
            end

            ACCESS: begin
                bus_addr    = addr_q;
                bus_ren     = ren_q;
                bus_wen     = wen_q;
                bus_wdata   = wdata_q;
                bus_byte_en = be_q;
                req_busy    = bus_busy;
                if (!bus_busy && !dropping) begin
                    req_rdata = bus_rdata;
                end
            end

            FAULT: begin
                fault_valid   = 1'b1;
                fault_store   = flt_store_q;
                fault_timeout = flt_tmo_q;
                fault_addr    = flt_addr_q;
                req_busy      = ~(fault_ack & ~flush);
            end

            default: begin
                req_busy = 1'b0;
            end
        endcase
    end

endmodule
